// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package router_pkg;

  localparam int ADDR_W    = 2;
  localparam int LEN_W     = 6;
  localparam int DATA_W    = 8;
  localparam int BUF_AW    = 6;
  localparam int BUF_DEPTH = 64;

  localparam logic [ADDR_W-1:0] MAX_ADDR = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } tx_state_e;

  // Router header byte: length in the upper six bits, destination port in the low two.
  function automatic logic [DATA_W-1:0] pack_hdr(input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: 64x8 register array, one write port, one read port, contents not reset.
// Latency: write lands on the clock edge; read data follows the (registered) read address combinationally.
// Backpressure: none; the transmitter decides when to write and which entry to read.
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              wr_en,
  input  logic [BUF_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [BUF_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];

  // Store one payload byte per accepted write.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a payload, then bursts header, payload and parity to the router.
// Latency: header appears the cycle after the last payload byte is accepted; burst is len+2 cycles when not stalled.
// Backpressure: router busy holds the current output byte and state; payload input is paced by pay_ready.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              ready,
  input  logic [DATA_W-1:0] pay_data,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              pkt_valid,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] GAP_CYC = 4'(GAP);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [BUF_AW-1:0] cnt_q, cnt_d;
  logic [BUF_AW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic [3:0]        gap_q, gap_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              ready_q, ready_d;
  logic              pay_ready_q, pay_ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              buf_wr_en;
  logic [DATA_W-1:0] buf_rd_dat;

  // A payload byte is taken only while loading and the handshake completes.
  assign buf_wr_en = (state_q == ST_LOAD) && pay_valid && pay_ready_q;

  router_tx_buf u_buf (
    .clock   (clock),
    .wr_en   (buf_wr_en),
    .wr_addr (cnt_q),
    .wr_dat  (pay_data),
    .rd_addr (idx_q),
    .rd_dat  (buf_rd_dat)
  );

  // Next-state and next-output logic; idx_q always points at the next payload byte to present.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    parity_d    = parity_q;
    gap_d       = gap_q;
    data_out_d  = data_out_q;
    pkt_valid_d = pkt_valid_q;
    ready_d     = ready_q;
    pay_ready_d = pay_ready_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((addr > MAX_ADDR) || (len == '0)) begin
            err_d = 1'b1;
          end else begin
            addr_d      = addr;
            len_d       = len;
            cnt_d       = '0;
            // Seed the running XOR with the header so the final value is ready as soon as loading ends.
            parity_d    = pack_hdr(len, addr);
            ready_d     = 1'b0;
            pay_ready_d = 1'b1;
            state_d     = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (pay_valid && pay_ready_q) begin
          parity_d = parity_q ^ pay_data;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == (len_q - 6'd1)) begin
            pay_ready_d = 1'b0;
            data_out_d  = pack_hdr(len_q, addr_q);
            pkt_valid_d = 1'b1;
            idx_d       = '0;
            state_d     = ST_HEADER;
          end
        end
      end

      ST_HEADER: begin
        if (!busy) begin
          data_out_d = buf_rd_dat;
          idx_d      = idx_q + 6'd1;
          state_d    = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (!busy) begin
          if (idx_q == len_q) begin
            data_out_d  = parity_q;
            pkt_valid_d = 1'b0;
            state_d     = ST_PARITY;
          end else begin
            data_out_d = buf_rd_dat;
            idx_d      = idx_q + 6'd1;
          end
        end
      end

      ST_PARITY: begin
        if (!busy) begin
          data_out_d = '0;
          done_d     = 1'b1;
          gap_d      = GAP_CYC;
          state_d    = ST_GAP;
        end
      end

      ST_GAP: begin
        // The done cycle is spent here too, so ready returns GAP+1 cycles after parity is consumed.
        if (gap_q == '0) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, parity and registered outputs; reset abandons any packet in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      parity_q    <= '0;
      gap_q       <= '0;
      data_out_q  <= '0;
      pkt_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      pay_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      parity_q    <= parity_d;
      gap_q       <= gap_d;
      data_out_q  <= data_out_d;
      pkt_valid_q <= pkt_valid_d;
      ready_q     <= ready_d;
      pay_ready_q <= pay_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign data_out  = data_out_q;
  assign pkt_valid = pkt_valid_q;
  assign ready     = ready_q;
  assign pay_ready = pay_ready_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for the router packet transmitter: table-driven packets and rejects plus reset/back-pressure sequences.
// Latency: checks are taken 1 time unit after each rising clock edge.
// Backpressure: busy is driven per cycle from the packet record.
module tb_router_pkt_tx;

  localparam int GAP = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] addr;
  logic [5:0] len;
  logic       ready;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    logic [7:0] base;      // payload byte i = base + i
    int         busy_pos;  // burst position where busy starts (-1 none)
    int         busy_cnt;
    int         stray_pos; // burst position where an illegal start is pulsed (-1 none)
    int         abort_pos; // burst position where reset is asserted (-1 none)
    bit         hold_next; // hold the next request high through the gap
    logic [7:0] exp_hdr;
    logic [7:0] exp_par;
  } pkt_t;

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
  } rej_t;

  pkt_t pkts[7];
  rej_t rejs[3];

  router_pkt_tx #(.GAP(GAP)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .addr      (addr),
    .len       (len),
    .ready     (ready),
    .pay_data  (pay_data),
    .pay_valid (pay_valid),
    .pay_ready (pay_ready),
    .busy      (busy),
    .data_out  (data_out),
    .pkt_valid (pkt_valid),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input pkt_t p, input int pos);
    if (pos == 0) return p.exp_hdr;
    if (pos == int'(p.len) + 1) return p.exp_par;
    return p.base + 8'(pos - 1);
  endfunction

  task automatic send_pkt(input pkt_t p, input pkt_t nxt);
    int  i;
    int  pos;
    int  bcnt;
    bit  gapped;
    chk("ready_before_req", 32'(ready), 32'd1);
    start = 1'b1;
    addr  = p.addr;
    len   = p.len;
    step();
    start = 1'b0;
    addr  = 2'd0;
    len   = 6'd0;
    chk("pay_ready_after_req", 32'(pay_ready), 32'd1);
    chk("ready_after_req", 32'(ready), 32'd0);

    // Load payload, with one pay_valid bubble after the second byte.
    i = 0;
    gapped = 1'b0;
    while (i < int'(p.len)) begin
      if (i == 2 && !gapped) begin
        pay_valid = 1'b0;
        gapped    = 1'b1;
      end else begin
        pay_valid = 1'b1;
        pay_data  = p.base + 8'(i);
        i++;
      end
      step();
      if (i < int'(p.len)) chk("pay_ready_loading", 32'(pay_ready), 32'd1);
    end
    pay_valid = 1'b0;
    chk("pay_ready_after_load", 32'(pay_ready), 32'd0);

    // Burst: header, payload, parity, honouring busy.
    pos  = 0;
    bcnt = p.busy_cnt;
    for (int cyc = 0; cyc < 200 && pos <= int'(p.len) + 1; cyc++) begin
      chk("data_out", 32'(data_out), 32'(exp_byte(p, pos)));
      chk("pkt_valid", 32'(pkt_valid), (pos <= int'(p.len)) ? 32'd1 : 32'd0);
      chk("done_in_burst", 32'(done), 32'd0);
      chk("err_in_burst", 32'(err), 32'd0);
      if (pos == p.abort_pos) begin
        #2;
        reset = 1'b1;
        #1;
        chk("abort_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("abort_pay_ready", 32'(pay_ready), 32'd0);
        chk("abort_data_out", 32'(data_out), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        step();
        reset = 1'b0;
        step();
        return;
      end
      start = (pos == p.stray_pos);
      addr  = 2'd3;
      len   = 6'd0;
      busy  = (pos == p.busy_pos) && (bcnt > 0);
      if (busy) bcnt--;
      else pos++;
      step();
      start = 1'b0;
      busy  = 1'b0;
      addr  = 2'd0;
    end
    if (pos != int'(p.len) + 2) begin
      errors++;
      $display("FAIL burst_timeout: got pos %0d expected %0d", pos, int'(p.len) + 2);
    end

    // done pulse, then ready returns GAP+1 cycles after the parity edge.
    chk("done_pulse", 32'(done), 32'd1);
    chk("ready_at_done", 32'(ready), 32'd0);
    chk("pkt_valid_at_done", 32'(pkt_valid), 32'd0);
    for (int g = 0; g < GAP; g++) begin
      if (p.hold_next) begin
        start = 1'b1;
        addr  = nxt.addr;
        len   = nxt.len;
      end
      step();
      chk("ready_in_gap", 32'(ready), 32'd0);
      chk("done_after_pulse", 32'(done), 32'd0);
      chk("err_in_gap", 32'(err), 32'd0);
    end
    step();
    chk("ready_after_gap", 32'(ready), 32'd1);
    if (!p.hold_next) begin
      start = 1'b0;
      addr  = 2'd0;
      len   = 6'd0;
    end
  endtask

  initial begin
    // addr len base busy_pos busy_cnt stray abort hold hdr par
    pkts[0] = '{2'd1, 6'd14, 8'h01, -1, 0,  3, -1, 1'b1, 8'h39, 8'h36}; // nominal, stray start, held next request
    pkts[1] = '{2'd1, 6'd14, 8'h01,  5, 3, -1, -1, 1'b0, 8'h39, 8'h36}; // busy on payload byte 5
    pkts[2] = '{2'd1, 6'd14, 8'h01, -1, 0, -1,  6, 1'b0, 8'h39, 8'h36}; // reset after byte 6
    pkts[3] = '{2'd2, 6'd1,  8'hAA, -1, 0, -1, -1, 1'b0, 8'h06, 8'hAC}; // single byte after reset
    pkts[4] = '{2'd0, 6'd63, 8'h00, 64, 1, -1, -1, 1'b0, 8'hFC, 8'hC3}; // max length, busy on parity
    pkts[5] = '{2'd2, 6'd3,  8'h10,  0, 2, -1, -1, 1'b0, 8'h0E, 8'h1D}; // busy on header
    pkts[6] = pkts[5];

    rejs[0] = '{2'd3, 6'd5};
    rejs[1] = '{2'd0, 6'd0};
    rejs[2] = '{2'd3, 6'd0};

    reset     = 1'b1;
    start     = 1'b0;
    addr      = 2'd0;
    len       = 6'd0;
    pay_data  = 8'h00;
    pay_valid = 1'b0;
    busy      = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_pay_ready", 32'(pay_ready), 32'd0);
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    step();

    for (int r = 0; r < 3; r++) begin
      start = 1'b1;
      addr  = rejs[r].addr;
      len   = rejs[r].len;
      step();
      start = 1'b0;
      chk("rej_err", 32'(err), 32'd1);
      chk("rej_ready", 32'(ready), 32'd1);
      chk("rej_pay_ready", 32'(pay_ready), 32'd0);
      chk("rej_pkt_valid", 32'(pkt_valid), 32'd0);
      step();
      chk("rej_err_clear", 32'(err), 32'd0);
      chk("rej_pkt_valid_after", 32'(pkt_valid), 32'd0);
    end

    for (int k = 0; k < 6; k++) begin
      send_pkt(pkts[k], pkts[k + 1]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
